rr_mux_sel_sequencer: RTL

- Round-robin source sequencer that sits directly upstream of the team's 5-to-1 8-bit data mux.
- Arbitrates among five per-source request lines and drives the mux's 3-bit select code.
- Holds each selection for a minimum dwell time and until the downstream consumer acknowledges.
- Qualifies the select with sel_valid, so the consumer knows when the mux output is meaningful.

---
 rtl/rr_mux_sel_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rr_mux_sel_sequencer.sv
// Round-robin sequencer driving the select code of the downstream 5-to-1 data mux.
// Optional watchdog abort compiled in with `define SEL_TIMEOUT_EN.
module rr_mux_sel_sequencer #(
  parameter int NUM_SRC        = 5,
  parameter int SEL_W          = 3,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               ack,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic [NUM_SRC-1:0] grant,
  output logic               busy,
  output logic               timeout
);

  localparam int DW_W = $clog2(HOLD_CYCLES + 1);

  if (NUM_SRC < 2 || NUM_SRC > 8 || (2 ** SEL_W) < NUM_SRC ||
      HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("rr_mux_sel_sequencer: illegal parameter combination");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_last;
  logic               r_sel_valid;
  logic [NUM_SRC-1:0] r_grant;
  logic               r_busy;
  logic [DW_W-1:0]    r_dwell;
  logic               r_ack_latch;

  logic               w_found;
  logic [SEL_W-1:0]   w_next_idx;
  logic [NUM_SRC-1:0] w_onehot;
  logic               w_done;
  logic               w_wd_expire;

  // Search upward from last+1, wrapping at NUM_SRC; the first hit wins.
  always_comb begin
    logic [SEL_W:0] v_sum;
    w_found    = 1'b0;
    w_next_idx = '0;
    v_sum      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      v_sum = {1'b0, r_last} + (SEL_W + 1)'(k);
      if (v_sum >= (SEL_W + 1)'(NUM_SRC)) begin
        v_sum = v_sum - (SEL_W + 1)'(NUM_SRC);
      end
      if (!w_found && req[v_sum[SEL_W-1:0]]) begin
        w_found    = 1'b1;
        w_next_idx = v_sum[SEL_W-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_onehot
    assign w_onehot[gi] = (w_next_idx == SEL_W'(gi));
  end

  // An ack seen earlier in the grant counts the same as one arriving now.
  assign w_done = (r_ack_latch | ack) & (r_dwell >= DW_W'(HOLD_CYCLES));

`ifdef SEL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd;
  logic            r_timeout;

  assign w_wd_expire = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_state == S_GRANT) && w_wd_expire && !w_done;
      if (r_state == S_IDLE) begin
        r_wd <= '0;
      end else if (!w_wd_expire) begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_wd_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_last      <= SEL_W'(NUM_SRC - 1);
      r_sel_valid <= 1'b0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_dwell     <= '0;
      r_ack_latch <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_sel       <= w_next_idx;
            r_grant     <= w_onehot;
            r_sel_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_dwell     <= DW_W'(1);
            r_ack_latch <= 1'b0;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (r_dwell < DW_W'(HOLD_CYCLES)) begin
            r_dwell <= r_dwell + 1'b1;
          end
          if (w_done || w_wd_expire) begin
            r_sel_valid <= 1'b0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_last      <= r_sel;
            r_ack_latch <= 1'b0;
            r_state     <= S_IDLE;
          end else if (ack) begin
            r_ack_latch <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sel       = r_sel;
  assign sel_valid = r_sel_valid;
  assign grant     = r_grant;
  assign busy      = r_busy;

endmodule
